// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Integer register file with same-cycle write-to-read bypass and a per-register
// busy scoreboard for long-latency producers (loads, CSR reads).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wb_rd_wen_i/idx_i/wdata_i  writeback write port (x0 writes dropped)
//   rsN_ren_i, rsN_idx_i    decode read requests (ren only gates stall_o)
//   rsN_rdata_o             combinational read data, bypassed from writeback
//   issue_set_i/rd_idx_i    marks rd busy from the next cycle on
//   rsN_busy_o              operand has an unresolved producer
//   stall_o                 decode must hold: an enabled operand is busy
//   busy_vec_o              raw scoreboard bits
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_rd_wen_i,
    input  logic [4:0]      wb_rd_idx_i,
    input  logic [XLEN-1:0] wb_rd_wdata_i,
    input  logic            rs1_ren_i,
    input  logic [4:0]      rs1_idx_i,
    input  logic            rs2_ren_i,
    input  logic [4:0]      rs2_idx_i,
    output logic [XLEN-1:0] rs1_rdata_o,
    output logic [XLEN-1:0] rs2_rdata_o,
    input  logic            issue_set_i,
    input  logic [4:0]      issue_rd_idx_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            stall_o,
    output logic [NREG-1:0] busy_vec_o
);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [XLEN-1:0] rs1_rdata_s;
    logic [XLEN-1:0] rs2_rdata_s;
    logic            rs1_busy_s;
    logic            rs2_busy_s;

    // Register storage: x0 is held at zero, all others take writeback data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            regs_r[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (wb_rd_wen_i && (wb_rd_idx_i == 5'(i))) begin
                    regs_r[i] <= wb_rd_wdata_i;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Scoreboard: a new issue to the same rd outranks the retiring writeback,
    // so the bit stays set for the new producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            busy_r[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (issue_set_i && (issue_rd_idx_i == 5'(i))) begin
                    busy_r[i] <= 1'b1;
                end else if (wb_rd_wen_i && (wb_rd_idx_i == 5'(i))) begin
                    busy_r[i] <= 1'b0;
                end else begin
                    busy_r[i] <= busy_r[i];
                end
            end
        end
    end

    // rs1 read and hazard: a writeback landing this cycle is forwarded and
    // therefore also resolves the busy condition.
    always_comb begin
        rs1_rdata_s = '0;
        rs1_busy_s  = 1'b0;
        if (rs1_idx_i == 5'd0) begin
            rs1_rdata_s = '0;
            rs1_busy_s  = 1'b0;
        end else if (wb_rd_wen_i && (wb_rd_idx_i == rs1_idx_i)) begin
            rs1_rdata_s = wb_rd_wdata_i;
            rs1_busy_s  = 1'b0;
        end else begin
            rs1_rdata_s = regs_r[rs1_idx_i];
            rs1_busy_s  = busy_r[rs1_idx_i];
        end
    end

    // rs2 read and hazard, same rules as rs1.
    always_comb begin
        rs2_rdata_s = '0;
        rs2_busy_s  = 1'b0;
        if (rs2_idx_i == 5'd0) begin
            rs2_rdata_s = '0;
            rs2_busy_s  = 1'b0;
        end else if (wb_rd_wen_i && (wb_rd_idx_i == rs2_idx_i)) begin
            rs2_rdata_s = wb_rd_wdata_i;
            rs2_busy_s  = 1'b0;
        end else begin
            rs2_rdata_s = regs_r[rs2_idx_i];
            rs2_busy_s  = busy_r[rs2_idx_i];
        end
    end

    assign rs1_rdata_o = rs1_rdata_s;
    assign rs2_rdata_o = rs2_rdata_s;
    assign rs1_busy_o  = rs1_busy_s;
    assign rs2_busy_o  = rs2_busy_s;
    assign stall_o     = (rs1_ren_i & rs1_busy_s) | (rs2_ren_i & rs2_busy_s);
    assign busy_vec_o  = busy_r;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_rd_wen_i;
    logic [4:0]  wb_rd_idx_i;
    logic [31:0] wb_rd_wdata_i;
    logic        rs1_ren_i;
    logic [4:0]  rs1_idx_i;
    logic        rs2_ren_i;
    logic [4:0]  rs2_idx_i;
    logic [31:0] rs1_rdata_o;
    logic [31:0] rs2_rdata_o;
    logic        issue_set_i;
    logic [4:0]  issue_rd_idx_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        stall_o;
    logic [31:0] busy_vec_o;

    regfile_sb #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_rd_wen_i(wb_rd_wen_i), .wb_rd_idx_i(wb_rd_idx_i), .wb_rd_wdata_i(wb_rd_wdata_i),
        .rs1_ren_i(rs1_ren_i), .rs1_idx_i(rs1_idx_i),
        .rs2_ren_i(rs2_ren_i), .rs2_idx_i(rs2_idx_i),
        .rs1_rdata_o(rs1_rdata_o), .rs2_rdata_o(rs2_rdata_o),
        .issue_set_i(issue_set_i), .issue_rd_idx_i(issue_rd_idx_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .stall_o(stall_o), .busy_vec_o(busy_vec_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        st;
        logic [31:0] bv;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    // Architectural reference: plain arrays of register values and busy flags.
    logic [31:0] ref_reg  [32];
    bit          ref_busy [32];

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            ref_reg[i]  = 32'd0;
            ref_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_rd_wen_i && wb_rd_idx_i == idx) return wb_rd_wdata_i;
        return ref_reg[idx];
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
        if (wb_rd_wen_i && wb_rd_idx_i == idx) return 1'b0;
        return ref_busy[idx];
    endfunction

    // Build the expectation for the current inputs and queue it.
    task automatic push_exp(input string name);
        exp_t e;
        e.name = name;
        e.d1   = exp_read(rs1_idx_i);
        e.d2   = exp_read(rs2_idx_i);
        e.b1   = exp_busy(rs1_idx_i);
        e.b2   = exp_busy(rs2_idx_i);
        e.st   = (rs1_ren_i & e.b1) | (rs2_ren_i & e.b2);
        e.bv   = 32'd0;
        for (int i = 0; i < 32; i++) e.bv[i] = ref_busy[i];
        q.push_back(e);
    endtask

    // Apply the effect of the coming clock edge to the reference model.
    task automatic model_edge();
        if (wb_rd_wen_i && wb_rd_idx_i != 5'd0) begin
            ref_reg[wb_rd_idx_i]  = wb_rd_wdata_i;
            ref_busy[wb_rd_idx_i] = 1'b0;
        end
        if (issue_set_i && issue_rd_idx_i != 5'd0) ref_busy[issue_rd_idx_i] = 1'b1;
    endtask

    task automatic drive(input logic wen, input logic [4:0] widx, input logic [31:0] wdata,
                         input logic r1en, input logic [4:0] r1, input logic r2en, input logic [4:0] r2,
                         input logic iss, input logic [4:0] iidx);
        wb_rd_wen_i = wen; wb_rd_idx_i = widx; wb_rd_wdata_i = wdata;
        rs1_ren_i = r1en; rs1_idx_i = r1; rs2_ren_i = r2en; rs2_idx_i = r2;
        issue_set_i = iss; issue_rd_idx_i = iidx;
    endtask

    // One full cycle: inputs applied just after posedge, checked at negedge.
    task automatic cycle(input string name, input logic wen, input logic [4:0] widx, input logic [31:0] wdata,
                         input logic r1en, input logic [4:0] r1, input logic r2en, input logic [4:0] r2,
                         input logic iss, input logic [4:0] iidx);
        drive(wen, widx, wdata, r1en, r1, r2en, r2, iss, iidx);
        push_exp(name);
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each queued expectation is
    // compared mid-cycle, well away from the active edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "rs1_rdata", rs1_rdata_o, e.d1);
                chk(e.name, "rs2_rdata", rs2_rdata_o, e.d2);
                chk(e.name, "rs1_busy", {31'd0, rs1_busy_o}, {31'd0, e.b1});
                chk(e.name, "rs2_busy", {31'd0, rs2_busy_o}, {31'd0, e.b2});
                chk(e.name, "stall", {31'd0, stall_o}, {31'd0, e.st});
                chk(e.name, "busy_vec", busy_vec_o, e.bv);
            end
        end
    end

    initial begin
        model_clear();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        cycle("reset_read", 0, 0, 0, 1, 5'd5, 1, 5'd31, 0, 0);
        cycle("bypass_x7", 1, 5'd7, 32'hDEADBEEF, 1, 5'd7, 0, 5'd0, 0, 0);
        cycle("stored_x7", 0, 0, 0, 0, 5'd0, 1, 5'd7, 0, 0);
        cycle("write_x0", 1, 5'd0, 32'h12345678, 1, 5'd0, 0, 5'd0, 0, 0);
        cycle("read_x0", 0, 0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0);
        cycle("issue_x0", 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
        cycle("issue_x3", 0, 0, 0, 1, 5'd3, 0, 5'd0, 1, 5'd3);
        cycle("busy_x3_a", 0, 0, 0, 1, 5'd3, 0, 5'd0, 0, 0);
        cycle("busy_x3_b", 0, 0, 0, 1, 5'd3, 0, 5'd0, 0, 0);
        cycle("wb_x3", 1, 5'd3, 32'hA5, 1, 5'd3, 0, 5'd0, 0, 0);
        cycle("after_x3", 0, 0, 0, 1, 5'd3, 0, 5'd0, 0, 0);
        cycle("set_clr_x9", 1, 5'd9, 32'h1, 0, 5'd9, 0, 5'd0, 1, 5'd9);
        cycle("after_x9", 0, 0, 0, 1, 5'd9, 0, 5'd0, 1, 5'd4);
        cycle("busy_x4_noren", 0, 0, 0, 0, 5'd0, 0, 5'd4, 0, 0);
        cycle("set_clr_diff", 1, 5'd4, 32'h44, 1, 5'd9, 1, 5'd4, 1, 5'd12);
        cycle("w10_s11", 1, 5'd10, 32'hFF, 0, 5'd10, 0, 5'd11, 1, 5'd11);
        cycle("pre_reset", 0, 0, 0, 1, 5'd10, 1, 5'd11, 0, 0);

        // Asynchronous reset between edges, with a write pending.
        drive(1'b1, 5'd10, 32'h77, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd13);
        #1 rst_n = 1'b0;
        model_clear();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b1, 5'd11, 1'b0, 5'd0);
        push_exp("in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("post_reset", 0, 0, 0, 1, 5'd10, 1, 5'd11, 0, 0);
        cycle("post_reset_13", 0, 0, 0, 1, 5'd13, 1, 5'd12, 0, 0);

        // Randomized traffic; indices drawn from a narrow range half the time
        // so bypass, set/clear collisions and stalls happen often.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a, b, c, d;
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            a = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
            b = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
            c = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
            d = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
            cycle("random", 1'($urandom_range(0, 1)), a, $urandom,
                  1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)), c,
                  1'($urandom_range(0, 1)), d);
        end

        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file at the receiving end of the writeback interface: accepts the writeback stage's rd write-enable, index and write data, and serves the decode stage's two source-operand reads.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for multi-cycle producers (loads, CSR reads), so decode can stall on unresolved operands.
- Sits between decode (read and issue side) and writeback (write side).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (index width fixed at 5)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wb_rd_wen_i  input  1  writeback write enable
wb_rd_idx_i  input  5  writeback destination index
wb_rd_wdata_i  input  XLEN  writeback data
rs1_ren_i  input  1  decode reads rs1 this cycle
rs1_idx_i  input  5  rs1 index
rs2_ren_i  input  1  decode reads rs2 this cycle
rs2_idx_i  input  5  rs2 index
rs1_rdata_o  output  XLEN  rs1 operand
rs2_rdata_o  output  XLEN  rs2 operand
issue_set_i  input  1  long-latency instruction issued this cycle; marks its rd busy
issue_rd_idx_i  input  5  rd of that instruction
rs1_busy_o  output  1  rs1 has an outstanding producer
rs2_busy_o  output  1  rs2 has an outstanding producer
stall_o  output  1  (rs1_ren_i & rs1_busy_o) | (rs2_ren_i & rs2_busy_o)
busy_vec_o  output  NREG  raw scoreboard, for debug and verification

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low. On assertion, all registers go to 0 and every busy bit goes to 0 immediately, without waiting for a clock edge. Deasserting reset in the middle of operation leaves everything cleared; no write pending at the time of reset takes effect.
- Write: on posedge clk, if wb_rd_wen_i and wb_rd_idx_i != 0, reg[wb_rd_idx_i] <= wb_rd_wdata_i. Writes to x0 are dropped. Register updates are visible one cycle after the write.
- Read: combinational, zero latency.
  - rsN_idx == 0 returns 0.
  - Else if wb_rd_wen_i and wb_rd_idx_i == rsN_idx, returns wb_rd_wdata_i (bypass).
  - Else returns reg[rsN_idx].
  - Read data is returned regardless of rsN_ren_i. The enable only affects stall_o.
- Scoreboard, one busy bit per register; busy[0] is permanently 0.
  - Set: posedge with issue_set_i and issue_rd_idx_i != 0 sets busy[issue_rd_idx_i].
  - Clear: posedge with wb_rd_wen_i and wb_rd_idx_i != 0 clears busy[wb_rd_idx_i].
  - Set and clear on the same index in the same cycle: set wins; the busy bit stays 1 for the new producer.
  - Set and clear on different indices: both apply.
  - Setting an index that is already busy keeps it busy. There is no counting, so only one outstanding producer per rd is allowed; decode guarantees this via stall_o.
- rsN_busy_o = busy[rsN_idx] & ~(wb_rd_wen_i & wb_rd_idx_i == rsN_idx). A writeback landing this cycle resolves the hazard through the bypass path. rsN_busy_o is 0 for index 0.
- issue_set_i does not affect the busy outputs in its own cycle; it takes effect from the next cycle.
- stall_o is purely combinational and has no registered state.
- Reset values of outputs:
  - rs1_rdata_o and rs2_rdata_o are 0 (all registers zero, no bypass active).
  - busy outputs, stall_o and busy_vec_o are 0.

Test Plan:
- Reset, then read rs1=5 and rs2=31 -> both 0, stall_o=0, busy_vec_o=0.
- Write x7=0xDEADBEEF; in the same cycle read rs1=7 -> rs1_rdata_o=0xDEADBEEF via bypass. Next cycle, with no write, read rs2=7 -> 0xDEADBEEF from storage.
- Write x0=0x12345678, then read rs1=0 -> 0. issue_set_i with rd=0 -> busy_vec_o stays 0.
- issue_set_i rd=3. Next cycle, rs1_ren=1 with rs1=3 -> rs1_busy_o=1 and stall_o=1. Two cycles later, wb write x3=0xA5 -> in that cycle rs1_busy_o=0, stall_o=0, rs1_rdata_o=0xA5. After the edge, busy[3]=0.
- In one cycle, issue_set_i rd=9 and wb write x9=0x1 -> after the edge busy[9]=1 and reg9=0x1. Also, with busy[4]=1 and rs2_ren_i=0, rs2=4 -> rs2_busy_o=1 but stall_o=0.
- Write x10=0xFF and set busy[11], then assert rst_n=0 between clock edges -> reg10 reads 0 and busy_vec_o=0 immediately. After release, the old values do not return.
